// File: rtl/dilator.sv
// Streaming binary dilation of a raster pixel stream with a WIN_SIZE x WIN_SIZE structuring element.
// Optional macro DILATOR_BYPASS_EN adds a `bypass` input that forwards the centre tap instead.

module dilator #(
  parameter int unsigned H_IMG_RES = 640,
  parameter int unsigned V_IMG_RES = 480,
  parameter int unsigned WIN_SIZE  = 5,
  parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'b01110_11111_11111_11111_01110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        in_pix,
`ifdef DILATOR_BYPASS_EN
  input  logic        bypass,
`endif
  output logic        out_valid,
  output logic [10:0] out_hpos,
  output logic [10:0] out_vpos,
  output logic        out_pix,
  output logic        sync_err
);

  localparam int unsigned R         = WIN_SIZE / 2;
  localparam int unsigned NTAP      = WIN_SIZE * WIN_SIZE;
  localparam int unsigned HIST_W    = (WIN_SIZE - 1) * H_IMG_RES + WIN_SIZE - 1;
  localparam int unsigned PRIME_LEN = R * H_IMG_RES + R;
  localparam int unsigned CNT_W     = $clog2(PRIME_LEN + 1);
  localparam int unsigned POS_W     = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [POS_W-1:0]  r_exp_h, r_exp_v, w_exp_h_nxt, w_exp_v_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_out_pix, w_out_pix_nxt;
  logic [POS_W-1:0]  r_out_hpos, r_out_vpos, w_out_hpos_nxt, w_out_vpos_nxt;
  logic              r_sync_err, w_sync_err_nxt;

  logic [HIST_W-1:0] r_hist;
  int                w_ox, w_oy;
  logic [WIN_SIZE-1:0] w_col_ok, w_row_ok;
  logic [NTAP-1:0]   w_hit;
  logic              w_dil, w_pix_sel;
  logic              w_origin, w_in_sync, w_eol, w_eof;

  // Pixel history: bit k-1 holds the pixel accepted k pixels before the current one.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_hist <= {r_hist[HIST_W-2:0], in_pix};
    end
  end

  // Output coordinate = input coordinate minus (R,R), wrapping to previous line/frame.
  always_comb begin
    w_ox = int'(hpos) - int'(R);
    w_oy = int'(vpos) - int'(R);
    if (w_ox < 0) begin
      w_ox = w_ox + int'(H_IMG_RES);
      w_oy = w_oy - 1;
    end
    if (w_oy < 0) begin
      w_oy = w_oy + int'(V_IMG_RES);
    end
  end

  for (genvar g = 0; g < WIN_SIZE; g++) begin : g_bound
    assign w_col_ok[g] = (w_ox + g - int'(R) >= 0) && (w_ox + g - int'(R) < int'(H_IMG_RES));
    assign w_row_ok[g] = (w_oy + g - int'(R) >= 0) && (w_oy + g - int'(R) < int'(V_IMG_RES));
  end

  // Tap (gi,gj) sits (2R-gi) lines and (2R-gj) pixels behind the newest input.
  for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < WIN_SIZE; gj++) begin : g_col
      localparam int unsigned K = (2 * R - gi) * H_IMG_RES + (2 * R - gj);
      localparam int unsigned B = NTAP - 1 - (gi * WIN_SIZE + gj);
      logic w_tap;
      if (K == 0) begin : g_live
        assign w_tap = in_pix;
      end else begin : g_hist
        assign w_tap = r_hist[K-1];
      end
      assign w_hit[gi*WIN_SIZE+gj] = STRUCT_ELM[B] & w_tap & w_col_ok[gj] & w_row_ok[gi];
    end
  end

  assign w_dil = |w_hit;

`ifdef DILATOR_BYPASS_EN
  assign w_pix_sel = bypass ? r_hist[PRIME_LEN-1] : w_dil;
`else
  assign w_pix_sel = w_dil;
`endif

  assign w_origin  = (hpos == '0) && (vpos == '0);
  assign w_in_sync = (hpos == r_exp_h) && (vpos == r_exp_v);
  assign w_eol     = (hpos == POS_W'(H_IMG_RES - 1));
  assign w_eof     = (vpos == POS_W'(V_IMG_RES - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Next-state, raster tracking and output staging.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_exp_h_nxt     = r_exp_h;
    w_exp_v_nxt     = r_exp_v;
    w_out_valid_nxt = 1'b0;
    w_sync_err_nxt  = 1'b0;
    w_out_pix_nxt   = r_out_pix;
    w_out_hpos_nxt  = r_out_hpos;
    w_out_vpos_nxt  = r_out_vpos;
    if (in_valid) begin
      if (w_eol) begin
        w_exp_h_nxt = '0;
        w_exp_v_nxt = w_eof ? '0 : vpos + POS_W'(1);
      end else begin
        w_exp_h_nxt = hpos + POS_W'(1);
        w_exp_v_nxt = vpos;
      end
      case (r_state)
        IDLE: begin
          if (w_origin) begin
            w_state_nxt = PRIME;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        PRIME, RUN: begin
          if (!w_in_sync) begin
            w_sync_err_nxt = 1'b1;
            w_state_nxt    = w_origin ? PRIME : IDLE;
            w_cnt_nxt      = w_origin ? CNT_W'(1) : '0;
          end else if (r_state == PRIME) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(PRIME_LEN)) begin
              w_state_nxt = RUN;
            end
          end else begin
            w_out_valid_nxt = 1'b1;
            w_out_pix_nxt   = w_pix_sel;
            w_out_hpos_nxt  = POS_W'(w_ox);
            w_out_vpos_nxt  = POS_W'(w_oy);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_exp_h     <= '0;
      r_exp_v     <= '0;
      r_out_valid <= 1'b0;
      r_out_pix   <= 1'b0;
      r_out_hpos  <= '0;
      r_out_vpos  <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_exp_h     <= w_exp_h_nxt;
      r_exp_v     <= w_exp_v_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_pix   <= w_out_pix_nxt;
      r_out_hpos  <= w_out_hpos_nxt;
      r_out_vpos  <= w_out_vpos_nxt;
      r_sync_err  <= w_sync_err_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pix   = r_out_pix;
  assign out_hpos  = r_out_hpos;
  assign out_vpos  = r_out_vpos;
  assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_dilator.sv
// Scoreboard bench for dilator on a reduced 16x12 raster with the default 5x5 element.
// Define DILATOR_BYPASS_EN to also exercise the bypass path.

module tb_dilator;

  localparam int H  = 16;
  localparam int V  = 12;
  localparam int W  = 5;
  localparam int R  = 2;
  localparam int PL = R * H + R;
  localparam logic [24:0] SE = 25'b01110_11111_11111_11111_01110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        in_pix;
  logic        out_valid;
  logic [10:0] out_hpos;
  logic [10:0] out_vpos;
  logic        out_pix;
  logic        sync_err;
  bit          m_byp;
`ifdef DILATOR_BYPASS_EN
  logic        bypass;
  assign bypass = m_byp;
`endif

  dilator #(
    .H_IMG_RES (H),
    .V_IMG_RES (V),
    .WIN_SIZE  (W),
    .STRUCT_ELM(SE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .hpos     (hpos),
    .vpos     (vpos),
    .in_pix   (in_pix),
`ifdef DILATOR_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_hpos (out_hpos),
    .out_vpos (out_vpos),
    .out_pix  (out_pix),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    bit p;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  bit   img[2][V][H];
  int   cur;
  int   n_cmp, n_err, n_push, n_pop, sync_exp, sync_seen;
  int   fcnt_q[$];
  int   facc;
  bit   m_sync;
  int   m_cnt, m_eh, m_ev;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference dilation of frame slot s at (x,y), zero outside the image.
  function automatic bit model_px(input int s, input int x, input int y, input bit byp);
    bit r;
    logic [24:0] sh;
    r = 1'b0;
    if (byp) return img[s][y][x];
    for (int dy = -R; dy <= R; dy++) begin
      for (int dx = -R; dx <= R; dx++) begin
        if (x + dx >= 0 && x + dx < H && y + dy >= 0 && y + dy < V) begin
          sh = SE >> (24 - ((dy + R) * W + dx + R));
          if (sh[0] && img[s][y+dy][x+dx]) r = 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Stream-level model: sync tracking, priming and expected-output generation.
  task automatic step(input int h, input int v);
    bit origin;
    int ox, oy, s;
    origin = (h == 0 && v == 0);
    if (!m_sync) begin
      if (origin) begin
        m_sync = 1'b1;
        m_cnt  = 1;
      end
    end else if (h != m_eh || v != m_ev) begin
      sync_exp++;
      m_sync = origin;
      m_cnt  = origin ? 1 : 0;
    end else if (m_cnt < PL) begin
      m_cnt++;
    end else begin
      ox = h - R;
      oy = v - R;
      if (ox < 0) begin
        ox += H;
        oy -= 1;
      end
      if (oy < 0) oy += V;
      s = (v * H + h < PL) ? 1 - cur : cur;
      sbq.push_back('{h: ox, v: oy, p: model_px(s, ox, oy, m_byp)});
      n_push++;
    end
    m_eh = (h == H - 1) ? 0 : h + 1;
    m_ev = (h == H - 1) ? ((v == V - 1) ? 0 : v + 1) : v;
  endtask

  task automatic drive(input int h, input int v, input bit p, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      @(negedge clk);
      in_valid = 1'b0;
      hpos     = 11'($urandom_range(2047));
      vpos     = 11'($urandom_range(2047));
      in_pix   = 1'($urandom_range(1));
    end
    @(negedge clk);
    in_valid = 1'b1;
    hpos     = 11'(h);
    vpos     = 11'(v);
    in_pix   = p;
    step(h, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    m_sync   = 1'b0;
    m_cnt    = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_pix", int'(out_pix), 0);
      check("rst_sync_err", int'(sync_err), 0);
    end
    check("rst_out_hpos", int'(out_hpos), 0);
    check("rst_out_vpos", int'(out_vpos), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One frame: random or single-pixel image, optional gaps, row glitch or mid-frame reset.
  task automatic send_frame(input bit rnd, input int sx, input int sy, input int gap_pct,
                            input int glitch_row, input int rst_row);
    cur = 1 - cur;
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        img[cur][v][h] = rnd ? 1'($urandom_range(1)) : (h == sx && v == sy);
    for (int v = 0; v < V; v++) begin
      for (int h = 0; h < H; h++) begin
        if (v == rst_row && h == 0) do_reset();
        if (v == glitch_row && h >= 6 && h <= 8) continue;
        drive(h, v, img[cur][v][h], gap_pct);
        if (v == glitch_row && h == 9) begin
          @(posedge clk);
          #1;
          check("glitch_sync_err", int'(sync_err), 1);
          check("glitch_out_valid", int'(out_valid), 0);
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard on every presented output.
  always @(negedge clk) begin
    if (sync_err) sync_seen++;
    if (out_valid) begin
      n_pop++;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got pixel %0d at (%0d,%0d) expected no output",
                 out_pix, out_hpos, out_vpos);
      end else begin
        mon_e = sbq.pop_front();
        if (int'(out_hpos) != mon_e.h || int'(out_vpos) != mon_e.v || out_pix != mon_e.p) begin
          n_err++;
          $display("FAIL out_px: got %0d at (%0d,%0d) expected %0d at (%0d,%0d)",
                   out_pix, out_hpos, out_vpos, mon_e.p, mon_e.h, mon_e.v);
        end
      end
      if (out_hpos == 0 && out_vpos == 0) facc = int'(out_pix);
      else facc += int'(out_pix);
      if (int'(out_hpos) == H - 1 && int'(out_vpos) == V - 1) fcnt_q.push_back(facc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    hpos     = '0;
    vpos     = '0;
    in_pix   = 1'b0;
    m_byp    = 1'b0;
    cur      = 0;
    do_reset();
    send_frame(1'b0, 8, 6, 0, -1, -1);
    send_frame(1'b0, 0, 0, 0, -1, -1);
    send_frame(1'b0, 15, 11, 0, -1, -1);
    send_frame(1'b0, -1, -1, 0, -1, -1);
    send_frame(1'b1, -1, -1, 0, 5, -1);
    send_frame(1'b1, -1, -1, 0, -1, -1);
    send_frame(1'b1, -1, -1, 30, -1, -1);
    send_frame(1'b1, -1, -1, 30, -1, -1);
    send_frame(1'b0, -1, -1, 30, -1, -1);
    send_frame(1'b1, -1, -1, 10, -1, 5);
    send_frame(1'b1, -1, -1, 10, -1, -1);
    send_frame(1'b0, -1, -1, 0, -1, -1);
`ifdef DILATOR_BYPASS_EN
    m_byp = 1'b1;
    send_frame(1'b1, -1, -1, 20, -1, -1);
    send_frame(1'b1, -1, -1, 0, -1, -1);
    send_frame(1'b0, -1, -1, 0, -1, -1);
    m_byp = 1'b0;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("queue_empty", sbq.size(), 0);
    check("out_count", n_pop, n_push);
    check("sync_pulses", sync_seen, sync_exp);
    check("sync_pulse_total", sync_seen, 1);
    check("frame_count_n", (fcnt_q.size() >= 3) ? 1 : 0, 1);
    if (fcnt_q.size() >= 3) begin
      check("ones_centre", fcnt_q[0], 21);
      check("ones_topleft", fcnt_q[1], 8);
      check("ones_botright", fcnt_q[2], 8);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
